mac_neuron: RTL

Second-generation single neuron. A handshake accepts an input vector, and one signed fixed-point multiply-accumulate runs per cycle over NUM_INPUTS entries. The result is rescaled, saturated and passed through a selectable activation. Weights and bias are run-time writable through a load port. Instanced per neuron inside a layer block; layer control drives the valid/ready ports.

---
 rtl/mac_neuron.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mac_neuron.sv
// mac_neuron: single neuron with a signed fixed-point multiply-accumulate.
//
// An input vector is taken on a valid/ready handshake, then one product
// vector[i]*weight[i] is accumulated per cycle. The accumulator is rescaled
// by FRAC_BITS, saturated to DATA_WIDTH and passed through the activation
// chosen by ACTIVATION ("relu", "linear" or "leaky"). Weights and the bias
// can be rewritten at run time whenever no computation is in flight.
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous, active-high reset
//   in_valid        input vector valid
//   in_ready        high in IDLE: a vector can be accepted
//   inputs          NUM_INPUTS signed entries, entry i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid       out holds a result
//   out_ready       consumer takes the result
//   out             signed activated result
//   weight_write    write strobe (honoured in IDLE and DONE only)
//   weight_address  0..NUM_INPUTS-1 selects a weight, NUM_INPUTS the bias
//   weight_data     value to write
module mac_neuron #(
  parameter int    DATA_WIDTH = 16,
  parameter int    FRAC_BITS  = 8,
  parameter int    NUM_INPUTS = 16,
  parameter string ACTIVATION = "relu"
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0]   inputs,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out,
  input  logic                               weight_write,
  input  logic [$clog2(NUM_INPUTS+1)-1:0]    weight_address,
  input  logic [DATA_WIDTH-1:0]              weight_data
);

  localparam int ADDR_W = $clog2(NUM_INPUTS + 1);
  localparam int IDX_W  = $clog2(NUM_INPUTS);
  localparam int PROD_W = 2 * DATA_WIDTH;
  // Wide enough for NUM_INPUTS full products plus the shifted bias.
  localparam int ACC_W  = 2 * DATA_WIDTH + $clog2(NUM_INPUTS) + 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_INPUTS - 1);
  localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(NUM_INPUTS);
  localparam logic [1:0] ACT_SEL = (ACTIVATION == "linear") ? 2'd1 :
                                   ((ACTIVATION == "leaky") ? 2'd2 : 2'd0);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MAC      = 2'd1,
    ST_ACTIVATE = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t                        state_r;
  state_t                        state_s;
  logic signed [DATA_WIDTH-1:0]  vector_r  [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0]  weights_r [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0]  bias_r;
  logic signed [ACC_W-1:0]       acc_r;
  logic [IDX_W-1:0]              index_r;
  logic signed [DATA_WIDTH-1:0]  out_r;
  logic                          in_ready_r;
  logic                          out_valid_r;

  logic signed [PROD_W-1:0]      prod_s;
  logic signed [ACC_W-1:0]       prod_ext_s;
  logic signed [ACC_W-1:0]       bias_ext_s;
  logic                          wr_en_s;

  // Rescale, saturate and activate an accumulator value.
  function automatic logic signed [DATA_WIDTH-1:0] activate(
    input logic signed [ACC_W-1:0] acc
  );
    logic signed [ACC_W-1:0]      x;
    logic signed [DATA_WIDTH-1:0] sat;
    logic signed [DATA_WIDTH-1:0] res;
    x = acc >>> FRAC_BITS;
    if (x > SAT_MAX) begin
      sat = SAT_MAX[DATA_WIDTH-1:0];
    end else if (x < SAT_MIN) begin
      sat = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat = x[DATA_WIDTH-1:0];
    end
    case (ACT_SEL)
      2'd0:    res = sat[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : sat;
      2'd1:    res = sat;
      2'd2:    res = sat[DATA_WIDTH-1] ? (sat >>> 3) : sat;
      default: res = sat;
    endcase
    return res;
  endfunction

  // Current product, sign-extended operands, plus accumulator-width views.
  always_comb begin
    prod_s     = PROD_W'(vector_r[index_r]) * PROD_W'(weights_r[index_r]);
    prod_ext_s = ACC_W'(prod_s);
    bias_ext_s = ACC_W'(bias_r) <<< FRAC_BITS;
    wr_en_s    = weight_write && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s = ST_MAC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (index_r == LAST_IDX) begin
          state_s = ST_ACTIVATE;
        end else begin
          state_s = ST_MAC;
        end
      end
      ST_ACTIVATE: state_s = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: vector capture, accumulation, result and handshake flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        vector_r[i] <= {DATA_WIDTH{1'b0}};
      end
      acc_r       <= {ACC_W{1'b0}};
      index_r     <= {IDX_W{1'b0}};
      out_r       <= {DATA_WIDTH{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
              vector_r[i] <= inputs[i*DATA_WIDTH +: DATA_WIDTH];
            end
            // bias_r is the pre-write value even if a write lands this edge.
            acc_r   <= bias_ext_s;
            index_r <= {IDX_W{1'b0}};
          end
        end
        ST_MAC: begin
          acc_r   <= acc_r + prod_ext_s;
          index_r <= index_r + IDX_W'(1);
        end
        ST_ACTIVATE: out_r <= activate(acc_r);
        ST_DONE: begin
        end
        default: begin
        end
      endcase
      in_ready_r  <= (state_s == ST_IDLE);
      out_valid_r <= (state_s == ST_DONE);
    end
  end

  // Weight and bias storage; writes only land while no computation runs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        weights_r[i] <= {DATA_WIDTH{1'b0}};
      end
      bias_r <= {DATA_WIDTH{1'b0}};
    end else if (wr_en_s) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (weight_address == ADDR_W'(i)) begin
          weights_r[i] <= weight_data;
        end
      end
      if (weight_address == BIAS_ADDR) begin
        bias_r <= weight_data;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out       = out_r;

endmodule
